// File: rtl/game_round_controller_if.sv
`default_nettype none
// ============================================================================
// Module : game_round_controller_if
// Brief  : Hit-event inputs and mixer/sprite status outputs of the round controller.
// Rev    : 1.0 - initial release
// ============================================================================
interface game_round_controller_if #(
    parameter int N_TARGETS = 3
);
    logic                 new_frame;
    logic [N_TARGETS-1:0] target_hit;
    logic                 spaceship_hit;
    logic                 pause_key;

    logic                 round_start;
    logic [N_TARGETS-1:0] target_alive;
    logic [2:0]           heart_en;
    logic [11:0]          score_bcd;
    logic                 end_of_game_timer_running;
    logic                 game_won;
    logic                 random;
    logic                 paused;

    modport master (
        output new_frame, target_hit, spaceship_hit, pause_key,
        input  round_start, target_alive, heart_en, score_bcd,
               end_of_game_timer_running, game_won, random, paused
    );

    modport slave (
        input  new_frame, target_hit, spaceship_hit, pause_key,
        output round_start, target_alive, heart_en, score_bcd,
               end_of_game_timer_running, game_won, random, paused
    );
endinterface
`default_nettype wire

// File: rtl/game_round_controller.sv
`default_nettype none
// ============================================================================
// Module : game_round_controller
// Brief  : Wave sequencer tracking targets, lives and BCD score for the mixer.
//          Optional pause support is enabled with `define GAME_ROUND_PAUSE_EN.
// Rev    : 1.0 - initial release
// ============================================================================
module game_round_controller #(
    parameter int          LIVES      = 3,
    parameter int          N_TARGETS  = 3,
    parameter int          HIT_FRAMES = 60,
    parameter int          END_CYCLES = 50000000,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  wire logic              clk,
    input  wire logic              rst,
    game_round_controller_if.slave bus
);

    localparam int c_FW = $clog2(HIT_FRAMES + 1);
    localparam int c_CW = $clog2(END_CYCLES + 1);
    localparam logic [c_FW-1:0]      c_FRAME_LAST = c_FW'(HIT_FRAMES - 1);
    localparam logic [c_CW-1:0]      c_END_LAST   = c_CW'(END_CYCLES - 1);
    localparam logic [N_TARGETS-1:0] c_ALL        = {N_TARGETS{1'b1}};
    localparam logic [1:0]           c_LIVES      = 2'(LIVES);

    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_PLAY  = 2'd1,
        S_HIT   = 2'd2,
        S_END   = 2'd3
    } state_t;

    function automatic logic [2:0] f_hearts(input logic [1:0] lives);
        f_hearts = {lives > 2'd2, lives > 2'd1, lives > 2'd0};
    endfunction

    function automatic logic [1:0] f_popcount(input logic [N_TARGETS-1:0] v);
        logic [1:0] c;
        c = '0;
        for (int i = 0; i < N_TARGETS; i++) c = c + 2'(v[i]);
        return c;
    endfunction

    // Digit-serial BCD add of 0..3; a carry out of the hundreds digit saturates.
    function automatic logic [11:0] f_bcd_add(input logic [11:0] s, input logic [1:0] n);
        logic [4:0] u, t, h;
        u = {1'b0, s[3:0]} + {3'b000, n};
        t = {1'b0, s[7:4]};
        h = {1'b0, s[11:8]};
        if (u > 5'd9) begin u = u - 5'd10; t = t + 5'd1; end
        if (t > 5'd9) begin t = t - 5'd10; h = h + 5'd1; end
        if (h > 5'd9) return 12'h999;
        return {h[3:0], t[3:0], u[3:0]};
    endfunction

    state_t               r_state, w_state;
    logic                 r_round_start, w_round_start;
    logic [N_TARGETS-1:0] r_target_alive, w_target_alive;
    logic [1:0]           r_lives, w_lives;
    logic [2:0]           r_heart_en;
    logic [11:0]          r_score, w_score;
    logic                 r_timer_running;
    logic                 r_game_won, w_game_won;
    logic                 r_paused, w_paused;
    logic [15:0]          r_lfsr, w_lfsr;
    logic [c_FW-1:0]      r_frame_cnt, w_frame_cnt;
    logic [c_CW-1:0]      r_cycle_cnt, w_cycle_cnt;
    logic [N_TARGETS-1:0] w_hits, w_alive_left;
    logic                 w_frozen;

    always_comb begin
        w_state        = r_state;
        w_round_start  = 1'b0;
        w_target_alive = r_target_alive;
        w_lives        = r_lives;
        w_score        = r_score;
        w_game_won     = r_game_won;
        w_paused       = r_paused;
        w_frame_cnt    = r_frame_cnt;
        w_cycle_cnt    = r_cycle_cnt;
        w_lfsr         = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        w_hits         = bus.target_hit & r_target_alive;
        w_alive_left   = r_target_alive & ~bus.target_hit;
        w_frozen       = 1'b0;

`ifdef GAME_ROUND_PAUSE_EN
        if (r_state == S_PLAY || r_state == S_HIT) begin
            w_frozen = r_paused;
            if (bus.pause_key) w_paused = ~r_paused;
        end
`endif

        case (r_state)
            S_START: begin
                w_round_start  = 1'b1;
                w_target_alive = c_ALL;
                // A won round carries lives and score into the next wave.
                if (!r_game_won) begin
                    w_lives = c_LIVES;
                    w_score = '0;
                end
                w_game_won = 1'b0;
                w_state    = S_PLAY;
            end
            S_PLAY, S_HIT: begin
                if (!w_frozen) begin
                    w_target_alive = w_alive_left;
                    w_score        = f_bcd_add(r_score, f_popcount(w_hits));
                    if (w_alive_left == '0) begin
                        w_game_won = 1'b1;
                        w_state    = S_END;
                    end else if (r_state == S_PLAY) begin
                        if (bus.spaceship_hit) begin
                            w_lives = r_lives - 2'd1;
                            if (r_lives == 2'd1) begin
                                w_game_won = 1'b0;
                                w_state    = S_END;
                            end else begin
                                w_state = S_HIT;
                            end
                        end
                    end else if (bus.new_frame) begin
                        if (r_frame_cnt == c_FRAME_LAST) w_state = S_PLAY;
                        else                             w_frame_cnt = r_frame_cnt + c_FW'(1);
                    end
                end
            end
            S_END: begin
                if (r_cycle_cnt == c_END_LAST) w_state = S_START;
                else                           w_cycle_cnt = r_cycle_cnt + c_CW'(1);
            end
            default: w_state = S_START;
        endcase

        if (w_state != r_state) begin
            w_frame_cnt = '0;
            w_cycle_cnt = '0;
        end
        if (w_state == S_END || w_state == S_START) w_paused = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_START;
            r_round_start   <= 1'b0;
            r_target_alive  <= c_ALL;
            r_lives         <= c_LIVES;
            r_heart_en      <= f_hearts(c_LIVES);
            r_score         <= '0;
            r_timer_running <= 1'b0;
            r_game_won      <= 1'b0;
            r_paused        <= 1'b0;
            r_lfsr          <= LFSR_SEED;
            r_frame_cnt     <= '0;
            r_cycle_cnt     <= '0;
        end else begin
            r_state         <= w_state;
            r_round_start   <= w_round_start;
            r_target_alive  <= w_target_alive;
            r_lives         <= w_lives;
            r_heart_en      <= f_hearts(w_lives);
            r_score         <= w_score;
            r_timer_running <= (w_state == S_END);
            r_game_won      <= w_game_won;
            r_paused        <= w_paused;
            r_lfsr          <= w_lfsr;
            r_frame_cnt     <= w_frame_cnt;
            r_cycle_cnt     <= w_cycle_cnt;
        end
    end

    assign bus.round_start               = r_round_start;
    assign bus.target_alive              = r_target_alive;
    assign bus.heart_en                  = r_heart_en;
    assign bus.score_bcd                 = r_score;
    assign bus.end_of_game_timer_running = r_timer_running;
    assign bus.game_won                  = r_game_won;
    assign bus.random                    = r_lfsr[0];
    assign bus.paused                    = r_paused;

endmodule
`default_nettype wire

// File: tb/tb_game_round_controller.sv
`default_nettype none
// ============================================================================
// Module : tb_game_round_controller
// Brief  : Directed + random stimulus against a decimal-score reference model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_game_round_controller;

    localparam int          LIVES      = 3;
    localparam int          N_TARGETS  = 3;
    localparam int          HIT_FRAMES = 4;
    localparam int          END_CYCLES = 20;
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;

    localparam int M_START = 0, M_PLAY = 1, M_HIT = 2, M_END = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    game_round_controller_if #(.N_TARGETS(N_TARGETS)) bus ();

    game_round_controller #(
        .LIVES     (LIVES),
        .N_TARGETS (N_TARGETS),
        .HIT_FRAMES(HIT_FRAMES),
        .END_CYCLES(END_CYCLES),
        .LFSR_SEED (LFSR_SEED)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int          m_state, m_lives, m_score, m_frames, m_timer;
    logic [2:0]  m_alive;
    logic        m_won, m_rs, m_paused;
    logic [15:0] m_lfsr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int s);
        return 12'(((s / 100) << 8) | (((s / 10) % 10) << 4) | (s % 10));
    endfunction

    function automatic logic [2:0] hearts(input int l);
        return {l > 2, l > 1, l > 0};
    endfunction

    task automatic model_reset();
        m_state = M_START; m_lives = LIVES; m_score = 0; m_frames = 0; m_timer = 0;
        m_alive = 3'b111; m_won = 1'b0; m_rs = 1'b0; m_paused = 1'b0; m_lfsr = LFSR_SEED;
    endtask

    task automatic model_step(input logic [2:0] th, input logic sh, input logic nf, input logic pk);
        int  n;
        bit  frozen;
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        m_rs   = 1'b0;
        frozen = 1'b0;
        case (m_state)
            M_START: begin
                m_rs = 1'b1; m_alive = 3'b111; m_paused = 1'b0;
                if (!m_won) begin m_lives = LIVES; m_score = 0; end
                m_state = M_PLAY;
            end
            M_PLAY, M_HIT: begin
`ifdef GAME_ROUND_PAUSE_EN
                frozen = m_paused;
                if (pk) m_paused = !m_paused;
`endif
                if (!frozen) begin
                    n = 0;
                    for (int i = 0; i < N_TARGETS; i++)
                        if (th[i] && m_alive[i]) begin m_alive[i] = 1'b0; n++; end
                    m_score = (m_score + n > 999) ? 999 : m_score + n;
                    if (m_alive == 3'b000) begin
                        m_won = 1'b1; m_state = M_END; m_timer = 0; m_paused = 1'b0;
                    end else if (m_state == M_PLAY) begin
                        if (sh) begin
                            m_lives--;
                            if (m_lives == 0) begin
                                m_won = 1'b0; m_state = M_END; m_timer = 0; m_paused = 1'b0;
                            end else begin
                                m_state = M_HIT; m_frames = 0;
                            end
                        end
                    end else if (nf) begin
                        m_frames++;
                        if (m_frames == HIT_FRAMES) m_state = M_PLAY;
                    end
                end
            end
            default: begin
                m_timer++;
                if (m_timer == END_CYCLES) m_state = M_START;
            end
        endcase
    endtask

    task automatic check_outputs();
        check("round_start",  bus.round_start, m_rs);
        check("target_alive", bus.target_alive, m_alive);
        check("heart_en",     bus.heart_en, hearts(m_lives));
        check("score_bcd",    bus.score_bcd, to_bcd(m_score));
        check("timer_running", bus.end_of_game_timer_running, m_state == M_END);
        if (m_state == M_END) check("game_won", bus.game_won, m_won);
        check("random", bus.random, m_lfsr[0]);
        check("paused", bus.paused, m_paused);
    endtask

    task automatic step(input logic [2:0] th, input logic sh, input logic nf, input logic pk);
        bus.target_hit = th; bus.spaceship_hit = sh; bus.new_frame = nf; bus.pause_key = pk;
        @(posedge clk);
        model_step(th, sh, nf, pk);
        #1;
        check_outputs();
        bus.target_hit = '0; bus.spaceship_hit = 1'b0; bus.new_frame = 1'b0; bus.pause_key = 1'b0;
    endtask

    task automatic wait_round();
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            step(3'b000, 1'b0, 1'b0, 1'b0);
            seen = bus.round_start;
        end
        if (!seen) check("round_start_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int cnt;
        bus.target_hit = '0; bus.spaceship_hit = 1'b0; bus.new_frame = 1'b0; bus.pause_key = 1'b0;
        model_reset();

        // Reset state and first round_start pulse
        #23;
        check_outputs();
        check("rst_alive", bus.target_alive, 3'b111);
        @(negedge clk) rst = 1'b0;
        step(3'b000, 1'b0, 1'b0, 1'b0);
        check("first_round_start", bus.round_start, 1'b1);
        step(3'b000, 1'b0, 1'b0, 1'b0);

        // Win by single hits; timer length and carried score/lives
        step(3'b001, 1'b0, 1'b0, 1'b0);
        step(3'b010, 1'b0, 1'b0, 1'b0);
        step(3'b100, 1'b0, 1'b0, 1'b0);
        check("win_score", bus.score_bcd, 12'h003);
        check("win_flag", bus.game_won, 1'b1);
        cnt = int'(bus.end_of_game_timer_running);
        for (int i = 0; i < 60 && !bus.round_start; i++) begin
            step(3'b000, 1'b0, 1'b0, 1'b0);
            cnt += int'(bus.end_of_game_timer_running);
        end
        check("timer_len", cnt, END_CYCLES);
        check("kept_score", bus.score_bcd, 12'h003);
        check("kept_lives", bus.heart_en, 3'b111);

        // Ship hit, ignored ship hit in S_HIT, repeat hit on dead target
        step(3'b001, 1'b0, 1'b0, 1'b0);
        step(3'b000, 1'b1, 1'b0, 1'b0);
        step(3'b000, 1'b1, 1'b0, 1'b0);
        step(3'b001, 1'b0, 1'b0, 1'b0);
        check("hit_lives", bus.heart_en, 3'b011);
        check("dead_score", bus.score_bcd, 12'h004);
        for (int i = 0; i < HIT_FRAMES; i++) step(3'b000, 1'b0, 1'b1, 1'b0);
        step(3'b000, 1'b1, 1'b0, 1'b0);
        check("lives_001", bus.heart_en, 3'b001);
        for (int i = 0; i < HIT_FRAMES; i++) step(3'b000, 1'b0, 1'b1, 1'b0);
        step(3'b000, 1'b1, 1'b0, 1'b0);
        check("lives_000", bus.heart_en, 3'b000);
        check("lost_flag", bus.game_won, 1'b0);
        wait_round();
        check("lost_score_reset", bus.score_bcd, 12'h000);

        // Simultaneous hit with ship hit; BCD carry and saturation
        for (int r = 1; r <= 334; r++) begin
            step(3'b111, 1'b1, 1'b0, 1'b0);
            if (r == 1)   check("all_hit_lives", bus.heart_en, 3'b111);
            if (r == 33)  check("score_099", bus.score_bcd, 12'h099);
            if (r == 34)  check("score_102", bus.score_bcd, 12'h102);
            if (r == 333) check("score_999", bus.score_bcd, 12'h999);
            if (r == 334) check("score_sat", bus.score_bcd, 12'h999);
            wait_round();
        end

`ifdef GAME_ROUND_PAUSE_EN
        begin
            logic [2:0] alive0;
            logic       r0;
            bit         toggled;
            step(3'b000, 1'b0, 1'b0, 1'b1);
            check("pause_on", bus.paused, 1'b1);
            alive0  = bus.target_alive;
            r0      = bus.random;
            toggled = 1'b0;
            for (int i = 0; i < 8; i++) begin
                step(3'b111, 1'b1, 1'b1, 1'b0);
                toggled |= (bus.random != r0);
            end
            check("pause_frozen", bus.target_alive, alive0);
            check("pause_random_runs", toggled, 1'b1);
            step(3'b000, 1'b0, 1'b0, 1'b1);
            check("pause_off", bus.paused, 1'b0);
            step(3'b001, 1'b0, 1'b0, 1'b0);
        end
`endif

        // Random play with a mid-operation reset
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] th;
            for (int b = 0; b < N_TARGETS; b++) th[b] = ($urandom_range(0, 15) == 0);
            step(th, $urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 30) == 0);
            if (i == 1500) begin
                rst = 1'b1;
                #2;
                model_reset();
                check_outputs();
                @(negedge clk) rst = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
